// File: rtl/push_ingress_arbiter.sv
// Round-robin ingress arbiter: per-port one-entry holding registers feeding a
// registered push toward the task generator. Optional macro: PIA_TREE_CHECK_EN.
module push_ingress_arbiter #(
  parameter int PORTS         = 4,
  parameter int PTW           = 16,
  parameter int TREE_NUM      = 4,
  parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
  parameter int MTW           = TREE_NUM_BITS,
  parameter int DW            = MTW + PTW,
  parameter int PW            = $clog2(PORTS)
) (
  input  logic                       i_clk,
  input  logic                       i_arst_n,
  input  logic [PORTS-1:0]           i_in_valid,
  output logic [PORTS-1:0]           o_in_ready,
  input  logic [PORTS*TREE_NUM_BITS-1:0] i_in_tree_id,
  input  logic [PORTS*PTW-1:0]       i_in_priority,
  input  logic [PORTS*DW-1:0]        i_in_data,
  input  logic                       i_task_fifo_full,
  output logic                       o_push,
  output logic [TREE_NUM_BITS-1:0]   o_push_tree_id,
  output logic [PTW-1:0]             o_push_priority,
  output logic [DW-1:0]              o_push_data,
  output logic [PW-1:0]              o_grant_port
`ifdef PIA_TREE_CHECK_EN
  ,
  output logic [15:0]                o_drop_cnt
`endif
);

  logic                     r_hold_v    [PORTS];
  logic [TREE_NUM_BITS-1:0] r_hold_tree [PORTS];
  logic [PTW-1:0]           r_hold_prio [PORTS];
  logic [DW-1:0]            r_hold_data [PORTS];
  logic [PW-1:0]            r_rr;

  logic                     r_push;
  logic [TREE_NUM_BITS-1:0] r_push_tree;
  logic [PTW-1:0]           r_push_prio;
  logic [DW-1:0]            r_push_data;
  logic [PW-1:0]            r_grant_port;

  logic [PORTS-1:0] w_hold_v;
  logic [PORTS-1:0] w_elig;
  logic [PORTS-1:0] w_hi;
  logic [PORTS-1:0] w_hi_first;
  logic [PORTS-1:0] w_all_first;
  logic [PORTS-1:0] w_gnt;
  logic [PORTS-1:0] w_accept;
  logic [PORTS-1:0] w_load;
  logic             w_any;

  // OR-chains over the one-hot grant build the winner index and its fields
  logic [PW-1:0]            w_win_c  [PORTS+1];
  logic [TREE_NUM_BITS-1:0] w_tree_c [PORTS+1];
  logic [PTW-1:0]           w_prio_c [PORTS+1];
  logic [DW-1:0]            w_data_c [PORTS+1];

  assign w_win_c[0]  = '0;
  assign w_tree_c[0] = '0;
  assign w_prio_c[0] = '0;
  assign w_data_c[0] = '0;

  assign w_elig = w_hold_v & {PORTS{~i_task_fifo_full}};
  assign w_any  = |w_elig;
  // Ports at or above the pointer win first; otherwise wrap to the lowest eligible
  assign w_gnt  = (|w_hi) ? w_hi_first : w_all_first;

`ifdef PIA_TREE_CHECK_EN
  logic [PORTS-1:0] w_drop;
  logic [PW:0]      w_drop_c [PORTS+1];
  logic [16:0]      w_drop_sum;
  logic [15:0]      r_drop_cnt;

  assign w_drop_c[0] = '0;
  assign w_drop_sum  = {1'b0, r_drop_cnt} + 17'(w_drop_c[PORTS]);
  assign o_drop_cnt  = r_drop_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < PORTS; gi++) begin : g_port
      assign w_hold_v[gi] = r_hold_v[gi];
      assign w_hi[gi]     = w_elig[gi] & (PW'(gi) >= r_rr);

      if (gi == 0) begin : g_first0
        assign w_hi_first[gi]  = w_hi[gi];
        assign w_all_first[gi] = w_elig[gi];
      end else begin : g_firstn
        assign w_hi_first[gi]  = w_hi[gi] & ~|w_hi[gi-1:0];
        assign w_all_first[gi] = w_elig[gi] & ~|w_elig[gi-1:0];
      end

      assign w_win_c[gi+1]  = w_win_c[gi]  | ({PW{w_gnt[gi]}} & PW'(gi));
      assign w_tree_c[gi+1] = w_tree_c[gi] | ({TREE_NUM_BITS{w_gnt[gi]}} & r_hold_tree[gi]);
      assign w_prio_c[gi+1] = w_prio_c[gi] | ({PTW{w_gnt[gi]}} & r_hold_prio[gi]);
      assign w_data_c[gi+1] = w_data_c[gi] | ({DW{w_gnt[gi]}} & r_hold_data[gi]);

      assign o_in_ready[gi] = ~r_hold_v[gi] | w_gnt[gi];
      assign w_accept[gi]   = i_in_valid[gi] & o_in_ready[gi];

`ifdef PIA_TREE_CHECK_EN
      assign w_drop[gi] = w_accept[gi] &
        ({1'b0, i_in_tree_id[gi*TREE_NUM_BITS +: TREE_NUM_BITS]} >= (TREE_NUM_BITS+1)'(TREE_NUM));
      assign w_load[gi] = w_accept[gi] & ~w_drop[gi];
      assign w_drop_c[gi+1] = w_drop_c[gi] + (PW+1)'(w_drop[gi]);
`else
      assign w_load[gi] = w_accept[gi];
`endif

      // A same-cycle refill wins over the clear from the grant
      always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
          r_hold_v[gi] <= 1'b0;
        end else if (w_load[gi]) begin
          r_hold_v[gi] <= 1'b1;
        end else if (w_gnt[gi]) begin
          r_hold_v[gi] <= 1'b0;
        end
      end

      always_ff @(posedge i_clk) begin
        if (w_load[gi]) begin
          r_hold_tree[gi] <= i_in_tree_id[gi*TREE_NUM_BITS +: TREE_NUM_BITS];
          r_hold_prio[gi] <= i_in_priority[gi*PTW +: PTW];
          r_hold_data[gi] <= i_in_data[gi*DW +: DW];
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      r_rr         <= '0;
      r_push       <= 1'b0;
      r_push_tree  <= '0;
      r_push_prio  <= '0;
      r_push_data  <= '0;
      r_grant_port <= '0;
    end else begin
      r_push <= w_any;
      if (w_any) begin
        r_rr         <= (w_win_c[PORTS] == PW'(PORTS-1)) ? '0 : w_win_c[PORTS] + 1'b1;
        r_push_tree  <= w_tree_c[PORTS];
        r_push_prio  <= w_prio_c[PORTS];
        r_push_data  <= w_data_c[PORTS];
        r_grant_port <= w_win_c[PORTS];
      end
    end
  end

  assign o_push          = r_push;
  assign o_push_tree_id  = r_push_tree;
  assign o_push_priority = r_push_prio;
  assign o_push_data     = r_push_data;
  assign o_grant_port    = r_grant_port;

endmodule

// File: tb/tb_push_ingress_arbiter.sv
// Scoreboard bench for push_ingress_arbiter: directed stimulus queues expected
// pushes, an independent monitor pops and compares on every o_push.
module tb_push_ingress_arbiter;
  localparam int PORTS = 4;
  localparam int PTW   = 16;
`ifdef PIA_TREE_CHECK_EN
  localparam int TREE_NUM = 3;
`else
  localparam int TREE_NUM = 4;
`endif
  localparam int TB = 2;
  localparam int DW = TB + PTW;
  localparam int PW = 2;

  typedef struct packed {
    logic [TB-1:0]  tree;
    logic [PTW-1:0] prio;
    logic [DW-1:0]  data;
  } req_t;

  typedef struct packed {
    logic [PW-1:0] port;
    req_t          r;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic [PORTS-1:0]      in_valid;
  logic [PORTS-1:0]      in_ready;
  logic [PORTS*TB-1:0]   in_tree;
  logic [PORTS*PTW-1:0]  in_prio;
  logic [PORTS*DW-1:0]   in_data;
  logic                  full;
  logic                  push;
  logic [TB-1:0]         push_tree;
  logic [PTW-1:0]        push_prio;
  logic [DW-1:0]         push_data;
  logic [PW-1:0]         grant_port;
`ifdef PIA_TREE_CHECK_EN
  logic [15:0]           drop_cnt;
`endif

  req_t drv_q [PORTS][$];
  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   push_cnt = 0;

  push_ingress_arbiter #(
    .PORTS(PORTS), .PTW(PTW), .TREE_NUM(TREE_NUM)
  ) dut (
    .i_clk           (clk),
    .i_arst_n        (rst_n),
    .i_in_valid      (in_valid),
    .o_in_ready      (in_ready),
    .i_in_tree_id    (in_tree),
    .i_in_priority   (in_prio),
    .i_in_data       (in_data),
    .i_task_fifo_full(full),
    .o_push          (push),
    .o_push_tree_id  (push_tree),
    .o_push_priority (push_prio),
    .o_push_data     (push_data),
    .o_grant_port    (grant_port)
`ifdef PIA_TREE_CHECK_EN
    ,
    .o_drop_cnt      (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send(input int p, input int tree, input int prio, input int data, input bit expect_it);
    req_t r;
    exp_t e;
    r.tree = TB'(tree);
    r.prio = PTW'(prio);
    r.data = DW'(data);
    drv_q[p].push_back(r);
    if (expect_it) begin
      e.port = PW'(p);
      e.r    = r;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int p = 0; p < PORTS; p++) drv_q[p].delete();
    @(negedge clk);
    check("rst_push", 64'(push), 64'd0);
    check("rst_ready", 64'(in_ready), 64'hF);
    check("rst_fields", {grant_port, push_tree, push_prio, push_data}, 64'd0);
`ifdef PIA_TREE_CHECK_EN
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Handshake driver: ready sampled at negedge, acceptance retired after posedge
  initial begin : driver
    logic [PORTS-1:0] acc;
    req_t r;
    in_valid = '0;
    in_tree  = '0;
    in_prio  = '0;
    in_data  = '0;
    forever begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < PORTS; p++) begin
        if (acc[p] && drv_q[p].size() > 0) void'(drv_q[p].pop_front());
        if (drv_q[p].size() > 0) begin
          r = drv_q[p][0];
          in_valid[p] = 1'b1;
        end else begin
          r = '0;
          in_valid[p] = 1'b0;
        end
        in_tree[p*TB +: TB]   = r.tree;
        in_prio[p*PTW +: PTW] = r.prio;
        in_data[p*DW +: DW]   = r.data;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (push === 1'b1) begin
        push_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_push: got port %0d data %0h, expected no push",
                   grant_port, push_data);
        end else begin
          e = exp_q.pop_front();
          $display("push port=%0d tree=%0d prio=%0d data=%0h", grant_port, push_tree, push_prio, push_data);
          check("push", 64'({grant_port, push_tree, push_prio, push_data}), 64'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: got no finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int c0;
    int n;
    int first;
    int last;
    rst_n = 1'b0;
    full  = 1'b0;
    repeat (3) @(negedge clk);
    check("init_push", 64'(push), 64'd0);
    check("init_fields", {grant_port, push_tree, push_prio, push_data}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("init_ready", 64'(in_ready), 64'hF);

    // Single push: visible on the third negedge after enqueue, for one cycle
    send(0, 1, 1, 4097, 1'b1);
    repeat (3) @(negedge clk);
    check("t1_latency", 64'(push), 64'd1);
    @(negedge clk);
    check("t1_one_cycle", 64'(push), 64'd0);
    drain();

    // Four ports continuously valid: strict rotation 0,1,2,3
    do_reset();
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < PORTS; p++)
        send(p, p % 3, 16 * p + i, 4096 * p + i, 1'b1);
    drain();

    // Full blocks grants; one non-full cycle leaks exactly one push
    do_reset();
    full = 1'b1;
    for (int p = 0; p < PORTS; p++) send(p, p % 3, 100 + p, 256 + p, 1'b1);
    c0 = push_cnt;
    repeat (6) @(negedge clk);
    check("t3_full_none", 64'(push_cnt - c0), 64'd0);
    full = 1'b0;
    @(negedge clk);
    full = 1'b1;
    repeat (10) @(negedge clk);
    check("t3_one_skid", 64'(push_cnt - c0), 64'd1);
    full = 1'b0;
    drain();
    check("t3_all_once", 64'(push_cnt - c0), 64'd4);

    // Back-to-back single port: twelve consecutive push cycles
    do_reset();
    for (int i = 0; i < 12; i++) send(2, i % 3, i, 4096 * i + 2, 1'b1);
    n = 0;
    first = -1;
    last = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (push === 1'b1) begin
        n++;
        if (first < 0) first = k;
        last = k;
      end
    end
    check("t4_count", 64'(n), 64'd12);
    check("t4_contiguous", 64'(last - first), 64'd11);
    drain();

    // Reset with held requests: nothing held may ever be emitted
    do_reset();
    full = 1'b1;
    for (int p = 0; p < 3; p++) send(p, p, 500 + p, 777 + p, 1'b0);
    repeat (4) @(negedge clk);
    do_reset();
    full = 1'b0;
    c0 = push_cnt;
    repeat (10) @(negedge clk);
    check("t5_no_stale", 64'(push_cnt - c0), 64'd0);

`ifdef PIA_TREE_CHECK_EN
    // Out-of-range tree id is swallowed and counted; next request flows
    send(1, 3, 7, 51, 1'b0);
    send(1, 2, 8, 68, 1'b1);
    repeat (8) @(negedge clk);
    check("t6_drop_cnt", 64'(drop_cnt), 64'd1);
    drain();
`endif

    drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
